simple_microprocessor: RTL and testbench

8-bit single-cycle accumulator-free CPU core with a 4×8 register file, 16×8 data memory and seven-segment debug outputs. It fetches from an external combinational instruction memory (IMEM) via `read_address`/`instruction`. It executes one instruction per step tick derived from `clk_in`. It sits at the top of the board design, driving hex displays of PC, instruction and last written data.

---
 rtl/simple_microprocessor.sv | 208 ++++++++++++++++++++
 tb/tb_simple_microprocessor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/simple_microprocessor.sv
// simple_microprocessor: 8-bit single-cycle core, 4x8 register file, 16x8 data memory, hex debug.
// Define CLKDIV_EN to step once per DIV_COUNT clk_in cycles instead of every cycle.
module simple_microprocessor #(
   parameter int DIV_COUNT = 4
) (
   input  logic       clk_in,
   input  logic       reset,
   input  logic [7:0] instruction,
   output logic [7:0] read_address,
   output logic [6:0] programcounter_one,
   output logic [6:0] programcounter_sixteen,
   output logic [6:0] instruction_one,
   output logic [6:0] instruction_sixteen,
   output logic [6:0] data_one,
   output logic [6:0] data_sixteen,
   output logic       clk_out,
   output logic       branch
);

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [1:0] rst_sync;
   logic       run;
   logic       tick;
   logic       step;

   // Reset asserts asynchronously but releases through two flops.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run = rst_sync[1];

`ifdef CLKDIV_EN
   localparam int CW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

   logic [CW-1:0] div_cnt;
   logic          clk_div;

   assign tick = (div_cnt == LAST);

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         clk_div <= 1'b0;
      end else if (run) begin
         if (tick) begin
            div_cnt <= '0;
            clk_div <= ~clk_div;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   assign clk_out = clk_div;
`else
   logic unused_div;

   assign unused_div = (DIV_COUNT > 0);
   assign tick       = 1'b1;
   assign clk_out    = clk_in;
`endif

   assign step = run & tick;

   logic [7:0] pc;
   logic [7:0] regs [4];
   logic [7:0] mem  [16];
   logic [7:0] data_q;

   logic [1:0] op;
   logic [1:0] rs;
   logic [1:0] rt;
   logic [1:0] rd;
   logic [5:0] off6;
   logic       is_lw;
   logic       is_sw;
   logic       is_add;
   logic       is_j;

   assign op   = instruction[7:6];
   assign rs   = instruction[5:4];
   assign rt   = instruction[3:2];
   assign rd   = instruction[1:0];
   assign off6 = instruction[5:0];

   assign is_lw  = (op == 2'b00);
   assign is_sw  = (op == 2'b01);
   assign is_add = (op == 2'b10);
   assign is_j   = (op == 2'b11);

   logic [7:0] rs_val;
   logic [7:0] rt_val;
   logic [7:0] sum;
   logic [3:0] mem_addr;
   logic [7:0] ld_val;
   logic [7:0] pc_inc;
   logic [7:0] pc_jmp;

   assign rs_val   = regs[rs];
   assign rt_val   = regs[rt];
   assign sum      = rs_val + rt_val;
   // Only the low nibble of base+offset addresses the 16-entry memory.
   assign mem_addr = rs_val[3:0] + {{2{rd[1]}}, rd};
   assign ld_val   = mem[mem_addr];
   assign pc_inc   = pc + 8'd1;
   assign pc_jmp   = pc_inc + {{2{off6[5]}}, off6};

   logic [7:0] pc_nxt;
   logic       reg_we;
   logic [1:0] reg_wa;
   logic [7:0] reg_wd;
   logic       mem_we;
   logic [7:0] data_nxt;

   always_comb begin
      pc_nxt   = pc_inc;
      reg_we   = 1'b0;
      reg_wa   = rd;
      reg_wd   = sum;
      mem_we   = 1'b0;
      data_nxt = data_q;
      unique case (1'b1)
         is_lw: begin
            reg_we   = 1'b1;
            reg_wa   = rt;
            reg_wd   = ld_val;
            data_nxt = ld_val;
         end
         is_sw: begin
            mem_we   = 1'b1;
            data_nxt = rt_val;
         end
         is_add: begin
            reg_we   = 1'b1;
            reg_wa   = rd;
            reg_wd   = sum;
            data_nxt = sum;
         end
         is_j: begin
            pc_nxt = pc_jmp;
         end
         default: begin
            pc_nxt = pc_inc;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         pc     <= 8'h00;
         data_q <= 8'h00;
         for (int i = 0; i < 4; i++) begin
            regs[i] <= 8'(i);
         end
         for (int i = 0; i < 16; i++) begin
            mem[i] <= 8'(i);
         end
      end else if (step) begin
         pc     <= pc_nxt;
         data_q <= data_nxt;
         if (reg_we) begin
            regs[reg_wa] <= reg_wd;
         end
         if (mem_we) begin
            mem[mem_addr] <= rt_val;
         end
      end
   end

   assign read_address = pc;
   assign branch       = is_j;

   assign programcounter_one     = hex7(pc[3:0]);
   assign programcounter_sixteen = hex7(pc[7:4]);
   assign instruction_one        = hex7(instruction[3:0]);
   assign instruction_sixteen    = hex7(instruction[7:4]);
   assign data_one               = hex7(data_q[3:0]);
   assign data_sixteen           = hex7(data_q[7:4]);

endmodule

// File: tb/tb_simple_microprocessor.sv
// tb_simple_microprocessor: table-driven program traces for simple_microprocessor.
// Bench-side IMEM feeds instruction combinationally from read_address.
module tb_simple_microprocessor;

   localparam int DIVN = 4;
`ifdef CLKDIV_EN
   localparam int STEP = DIVN;
`else
   localparam int STEP = 1;
`endif

   localparam logic [6:0] SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic       clk_in = 1'b0;
   logic       reset;
   logic [7:0] instruction;
   logic [7:0] read_address;
   logic [6:0] programcounter_one;
   logic [6:0] programcounter_sixteen;
   logic [6:0] instruction_one;
   logic [6:0] instruction_sixteen;
   logic [6:0] data_one;
   logic [6:0] data_sixteen;
   logic       clk_out;
   logic       branch;

   logic [7:0] imem [256];

   assign instruction = imem[read_address];

   simple_microprocessor #(.DIV_COUNT(DIVN)) dut (
      .clk_in                 (clk_in),
      .reset                  (reset),
      .instruction            (instruction),
      .read_address           (read_address),
      .programcounter_one     (programcounter_one),
      .programcounter_sixteen (programcounter_sixteen),
      .instruction_one        (instruction_one),
      .instruction_sixteen    (instruction_sixteen),
      .data_one               (data_one),
      .data_sixteen           (data_sixteen),
      .clk_out                (clk_out),
      .branch                 (branch)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0] pc;
      logic [7:0] data;
      logic       br;
   } vec_t;

   vec_t vec [23];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_row(input int i);
      logic [7:0] ins;
      ins = imem[vec[i].pc];
      check($sformatf("pc[%0d]", i), read_address, vec[i].pc);
      check($sformatf("pc_lo[%0d]", i), programcounter_one, SEG[vec[i].pc[3:0]]);
      check($sformatf("pc_hi[%0d]", i), programcounter_sixteen, SEG[vec[i].pc[7:4]]);
      check($sformatf("ins_lo[%0d]", i), instruction_one, SEG[ins[3:0]]);
      check($sformatf("ins_hi[%0d]", i), instruction_sixteen, SEG[ins[7:4]]);
      check($sformatf("data_lo[%0d]", i), data_one, SEG[vec[i].data[3:0]]);
      check($sformatf("data_hi[%0d]", i), data_sixteen, SEG[vec[i].data[7:4]]);
      check($sformatf("branch[%0d]", i), branch, vec[i].br);
   endtask

   task automatic run_rows(input int lo, input int hi);
      int k;
      for (k = 0; k < 20; k++) begin
         @(negedge clk_in);
         if (read_address != 8'h00) break;
      end
      check("first_step_seen", (k < 20), 1'b1);
      check_row(lo);
      for (int i = lo + 1; i <= hi; i++) begin
         repeat (STEP) @(negedge clk_in);
         check_row(i);
      end
   endtask

   task automatic fill_imem();
      for (int a = 0; a < 256; a++) imem[a] = 8'hBF;
   endtask

   initial begin
      vec[0]  = '{8'h01, 8'h03, 1'b0};
      vec[1]  = '{8'h02, 8'h02, 1'b0};
      vec[2]  = '{8'h03, 8'h03, 1'b0};
      vec[3]  = '{8'h04, 8'h03, 1'b0};
      vec[4]  = '{8'h05, 8'h05, 1'b1};
      vec[5]  = '{8'h07, 8'h05, 1'b0};
      vec[6]  = '{8'h08, 8'h06, 1'b1};
      vec[7]  = '{8'h0B, 8'h06, 1'b1};
      vec[8]  = '{8'h0A, 8'h06, 1'b1};
      vec[9]  = '{8'h0F, 8'h06, 1'b1};
      vec[10] = '{8'hFF, 8'h06, 1'b1};
      vec[11] = '{8'h00, 8'h06, 1'b0};
      vec[12] = '{8'h01, 8'h09, 1'b0};
      vec[13] = '{8'h01, 8'h02, 1'b0};
      vec[14] = '{8'h02, 8'h02, 1'b0};
      vec[15] = '{8'h03, 8'h04, 1'b0};
      vec[16] = '{8'h04, 8'h08, 1'b0};
      vec[17] = '{8'h05, 8'h10, 1'b0};
      vec[18] = '{8'h06, 8'h20, 1'b0};
      vec[19] = '{8'h07, 8'h40, 1'b0};
      vec[20] = '{8'h08, 8'h80, 1'b0};
      vec[21] = '{8'h09, 8'h80, 1'b0};
      vec[22] = '{8'h0A, 8'h00, 1'b0};

      fill_imem();
      imem[0]   = 8'h9B;
      imem[1]   = 8'h33;
      imem[2]   = 8'h4C;
      imem[3]   = 8'h04;
      imem[4]   = 8'h86;
      imem[5]   = 8'hC1;
      imem[7]   = 8'h9E;
      imem[8]   = 8'hC2;
      imem[10]  = 8'hC4;
      imem[11]  = 8'hFE;
      imem[15]  = 8'hEF;
      imem[255] = 8'hC0;

      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk_in);

      check("rst_pc", read_address, 8'h00);
      check("rst_branch", branch, 1'b0);
      check("rst_pc_lo", programcounter_one, 7'h40);
      check("rst_pc_hi", programcounter_sixteen, 7'h40);
      check("rst_data_lo", data_one, 7'h40);
      check("rst_data_hi", data_sixteen, 7'h40);
      check("rst_ins_lo", instruction_one, 7'h03);
      check("rst_ins_hi", instruction_sixteen, 7'h10);
`ifdef CLKDIV_EN
      check("rst_clk_out", clk_out, 1'b0);
`else
      check("clk_out_low", clk_out, clk_in);
      @(posedge clk_in);
      #1;
      check("clk_out_high", clk_out, clk_in);
      @(negedge clk_in);
`endif

      reset = 1'b1;
      run_rows(0, 12);

      // Abort mid-run, then confirm registers and memory came back to index values.
      @(negedge clk_in);
      reset = 1'b0;
      #1;
      check("midrst_pc", read_address, 8'h00);
      check("midrst_data_lo", data_one, 7'h40);
      check("midrst_data_hi", data_sixteen, 7'h40);
      check("midrst_branch", branch, 1'b0);

      fill_imem();
      imem[0] = 8'h2C;
      for (int a = 1; a <= 7; a++) imem[a] = 8'h95;
      imem[8] = 8'h92;
      imem[9] = 8'h9B;

      @(negedge clk_in);
      reset = 1'b1;
      run_rows(13, 22);

`ifdef CLKDIV_EN
      begin
         logic prev;
         int   last;
         int   gap;
         prev = clk_out;
         last = -1;
         gap  = 0;
         for (int k = 0; k < 40; k++) begin
            @(posedge clk_in);
            #1;
            if (clk_out !== prev) begin
               if (last >= 0 && gap == 0) gap = k - last;
               last = k;
            end
            prev = clk_out;
         end
         check("clk_out_half_period", gap, DIVN);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
